// File: rtl/loop_down_counter_pkg.sv
// Shared definitions for the loop countdown counter: state encoding and its typed view.
package loop_down_counter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Encoding 2'd3 is unreachable and is treated as idle by the controller.
    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE,
        StRsvd = 2'd3
    } state_e;

endpackage

// File: rtl/loop_down_counter_dec.sv
// Combinational decrementer (d = a - 1), modulo 2^DATAWIDTH.
module loop_down_counter_dec #(
    parameter int unsigned DATAWIDTH = 64
) (
    input  logic [DATAWIDTH-1:0] a_i,
    output logic [DATAWIDTH-1:0] d_o
);

    assign d_o = a_i - DATAWIDTH'(1);

endmodule

// File: rtl/loop_down_counter.sv
// Loadable countdown counter for loop control: tracks remaining and completed iterations,
// pulses done for one cycle when the loop completes naturally.
module loop_down_counter
    import loop_down_counter_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] load_val,
    input  logic                 step_en,
    input  logic                 halt,
    output logic [DATAWIDTH-1:0] count,
    output logic [DATAWIDTH-1:0] iter,
    output logic                 busy,
    output logic                 zero,
    output logic                 done
);

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   count_q, count_d;
    logic [DATAWIDTH-1:0]   iter_q, iter_d;
    logic [DATAWIDTH-1:0]   count_dec;

    loop_down_counter_dec #(
        .DATAWIDTH(DATAWIDTH)
    ) u_count_dec (
        .a_i(count_q),
        .d_o(count_dec)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        iter_d  = iter_q;
        case (state_q)
            StRun: begin
                if (halt) begin
                    state_d = StIdle;
                end else if (step_en) begin
                    iter_d = iter_q + DATAWIDTH'(1);
                    // Final step clamps to zero so the count can never wrap below 0.
                    if (count_q > DATAWIDTH'(1)) begin
                        count_d = count_dec;
                    end else begin
                        count_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                if (start) begin
                    iter_d = '0;
                    if (load_val != '0) begin
                        count_d = load_val;
                        state_d = StRun;
                    end else begin
                        count_d = '0;
                        state_d = StDone;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            count_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            iter_q  <= iter_d;
        end
    end

    assign count = count_q;
    assign iter  = iter_q;
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_loop_down_counter.sv
// Scoreboard bench for loop_down_counter at DATAWIDTH=8.
module tb_loop_down_counter;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] count;
        logic [W-1:0] iter;
        logic         busy;
        logic         zero;
        logic         done;
    } out_t;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         step_en = 1'b0;
    logic         halt = 1'b0;
    logic [W-1:0] count;
    logic [W-1:0] iter;
    logic         busy;
    logic         zero;
    logic         done;

    int checks = 0;
    int errors = 0;

    out_t sb[$];

    // Reference model state: 0 idle, 1 run, 2 done.
    int           m_state = 0;
    logic [W-1:0] m_count = '0;
    logic [W-1:0] m_iter  = '0;

    always #5 Clk = ~Clk;

    loop_down_counter #(
        .DATAWIDTH(W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .load_val(load_val),
        .step_en (step_en),
        .halt    (halt),
        .count   (count),
        .iter    (iter),
        .busy    (busy),
        .zero    (zero),
        .done    (done)
    );

    function automatic out_t observe();
        out_t o;
        o.count = count;
        o.iter  = iter;
        o.busy  = busy;
        o.zero  = zero;
        o.done  = done;
        return o;
    endfunction

    // Apply one cycle of stimulus, advance the model, push the expected outputs.
    task automatic drive(input logic r, input logic s, input logic [W-1:0] lv,
                         input logic se, input logic h);
        out_t e;
        Rst = r; start = s; load_val = lv; step_en = se; halt = h;
        if (r) begin
            m_state = 0; m_count = '0; m_iter = '0;
        end else begin
            case (m_state)
                1: begin
                    if (h) begin
                        m_state = 0;
                    end else if (se) begin
                        m_iter = m_iter + 1'b1;
                        if (m_count == 1) begin
                            m_count = '0;
                            m_state = 2;
                        end else begin
                            m_count = m_count - 1'b1;
                        end
                    end
                end
                2: m_state = 0;
                default: begin
                    if (s) begin
                        m_iter = '0;
                        m_count = lv;
                        m_state = (lv != 0) ? 1 : 2;
                    end
                end
            endcase
        end
        e.count = m_count;
        e.iter  = m_iter;
        e.busy  = (m_state == 1);
        e.zero  = (m_count == 0);
        e.done  = (m_state == 2);
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        out_t e, o;
        drive(1, 0, 0, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_init got %h want %h", o, e); end
        checks++;
        if (o !== {8'd0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_init_const got %h", o);
        end
        drive(0, 1, 8'd5, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_load got %h want %h", o, e); end
        drive(0, 0, 0, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_hold got %h want %h", o, e); end
        drive(1, 1, 8'd7, 1, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_mid got %h want %h", o, e); end
        checks++;
        if (o !== {8'd0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_mid_const got %h", o);
        end
    endtask

    task automatic test_normal();
        out_t e, o;
        drive(0, 1, 8'd3, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL normal_start got %h want %h", o, e); end
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 1, 0);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL normal_step%0d got %h want %h", i, o, e);
            end
            checks++;
            if (count !== 8'(3 - i) || done !== (i == 3)) begin
                errors++;
                $display("FAIL normal_step%0d_const got count %0d done %b", i, count, done);
            end
        end
        drive(0, 0, 0, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL normal_after got %h want %h", o, e); end
        checks++;
        if (iter !== 8'd3 || done !== 1'b0) begin
            errors++; $display("FAIL normal_iter got iter %0d done %b want 3 0", iter, done);
        end
    endtask

    task automatic test_zero_trip();
        out_t e, o;
        int dones = 0;
        int busies = 0;
        drive(0, 1, 8'd0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL zero_trip_cyc%0d got %h want %h", i, o, e);
            end
            if (done) dones++;
            if (busy) busies++;
            if (i < 2) drive(0, 0, 0, 0, 0);
        end
        checks++;
        if (dones != 1 || busies != 0 || count !== 8'd0) begin
            errors++;
            $display("FAIL zero_trip_pulse got dones %0d busy %0d count %0d want 1 0 0",
                     dones, busies, count);
        end
    endtask

    task automatic test_priority();
        out_t e, o;
        drive(0, 1, 8'd4, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL prio_start got %h want %h", o, e); end
        drive(0, 1, 8'd9, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL prio_busy_start got %h want %h", o, e); end
        checks++;
        if (count !== 8'd4 || busy !== 1'b1) begin
            errors++; $display("FAIL prio_no_reload got count %0d busy %b want 4 1", count, busy);
        end
        drive(0, 0, 0, 1, 1);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL prio_halt got %h want %h", o, e); end
        checks++;
        if (count !== 8'd4 || iter !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL prio_halt_const got count %0d iter %0d busy %b done %b want 4 0 0 0",
                     count, iter, busy, done);
        end
        drive(0, 0, 0, 1, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL prio_idle_step got %h want %h", o, e); end
    endtask

    task automatic test_width_edge();
        out_t e, o;
        logic se;
        int steps = 0;
        int dones = 0;
        int bad = 0;
        drive(0, 1, 8'hFF, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL width_start got %h want %h", o, e); end
        for (int cyc = 0; cyc < 2000 && steps < 255; cyc++) begin
            se = 1'($urandom_range(0, 1));
            drive(0, 0, 0, se, 0);
            if (se) steps++;
            e = sb.pop_front(); o = observe();
            if (o !== e) begin
                bad++;
                if (bad < 4) $display("FAIL width_cyc%0d got %h want %h", cyc, o, e);
            end
            if (done) dones++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL width_trace got %0d bad cycles want 0", bad); end
        checks++;
        if (steps != 255 || dones != 1 || iter !== 8'hFF || count !== 8'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL width_end got steps %0d dones %0d iter %h count %h zero %b",
                     steps, dones, iter, count, zero);
        end
        drive(0, 0, 0, 1, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL width_after got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        drive(0, 1, 8'd1, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_start got %h want %h", o, e); end
        drive(0, 0, 0, 1, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_done got %h want %h", o, e); end
        drive(0, 1, 8'd2, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_in_done got %h want %h", o, e); end
        checks++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            errors++; $display("FAIL b2b_ignored got busy %b count %0d want 0 0", busy, count);
        end
        drive(0, 1, 8'd2, 0, 0);
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_reload got %h want %h", o, e); end
        checks++;
        if (busy !== 1'b1 || count !== 8'd2 || iter !== 8'd0) begin
            errors++;
            $display("FAIL b2b_reload_const got busy %b count %0d iter %0d want 1 2 0",
                     busy, count, iter);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0);
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL b2b_run%0d got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_trip();
        test_priority();
        test_width_edge();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
